// File: rtl/switch_debounce_filter_if.sv
// Switch debouncer signal bundle: raw pin in, clean level and edge strobes out.
// The filter takes the slave modport; the switch/pin side takes the master modport.
interface switch_debounce_filter_if;
  logic i_Switch;
  logic o_Switch;
  logic o_Rise;
  logic o_Fall;

  modport master (
    output i_Switch,
    input  o_Switch,
    input  o_Rise,
    input  o_Fall
  );

  modport slave (
    input  i_Switch,
    output o_Switch,
    output o_Rise,
    output o_Fall
  );
endinterface

// File: rtl/switch_debounce_filter.sv
// Synchronises a bouncy push-button and accepts a new level only after it holds
// for DEBOUNCE_LIMIT consecutive samples; emits a clean level plus rise/fall strobes.
module switch_debounce_filter #(
  parameter int unsigned DEBOUNCE_LIMIT = 250000,
  parameter int unsigned CNT_WIDTH      = 18,
  parameter int unsigned SYNC_STAGES    = 2
) (
  input logic                    i_Clk,
  input logic                    i_Rst_L,
  switch_debounce_filter_if.slave sw_if
);

  if (DEBOUNCE_LIMIT < 2) begin : g_bad_limit
    $error("DEBOUNCE_LIMIT must be >= 2");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("SYNC_STAGES must be >= 2");
  end
  if (((64'(DEBOUNCE_LIMIT) - 64'd1) >> CNT_WIDTH) != 64'd0) begin : g_bad_width
    $error("DEBOUNCE_LIMIT-1 does not fit in CNT_WIDTH bits");
  end

  localparam logic [CNT_WIDTH-1:0] CntMax = CNT_WIDTH'(DEBOUNCE_LIMIT - 1);
  localparam logic [CNT_WIDTH-1:0] CntOne = CNT_WIDTH'(1);

  typedef enum logic [1:0] {
    StStableLow,
    StWaitHigh,
    StStableHigh,
    StWaitLow
  } state_e;

  state_e                 state_q, state_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   switch_q, switch_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   s;

  assign sync_d = {sync_q[SYNC_STAGES-2:0], sw_if.i_Switch};
  assign s      = sync_q[SYNC_STAGES-1];

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      sync_q   <= '0;
      state_q  <= StStableLow;
      cnt_q    <= '0;
      switch_q <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      switch_q <= switch_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
    end
  end

  // Any sample matching the current clean level throws away the partial count.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    switch_d = switch_q;
    rise_d   = 1'b0;
    fall_d   = 1'b0;
    unique case (state_q)
      StStableLow: begin
        cnt_d = '0;
        if (s) begin
          state_d = StWaitHigh;
          cnt_d   = CntOne;
        end
      end
      StWaitHigh: begin
        if (!s) begin
          state_d = StStableLow;
          cnt_d   = '0;
        end else if (cnt_q == CntMax) begin
          state_d  = StStableHigh;
          cnt_d    = '0;
          switch_d = 1'b1;
          rise_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      StStableHigh: begin
        cnt_d = '0;
        if (!s) begin
          state_d = StWaitLow;
          cnt_d   = CntOne;
        end
      end
      StWaitLow: begin
        if (s) begin
          state_d = StStableHigh;
          cnt_d   = '0;
        end else if (cnt_q == CntMax) begin
          state_d  = StStableLow;
          cnt_d    = '0;
          switch_d = 1'b0;
          fall_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      default: begin
        state_d = StStableLow;
        cnt_d   = '0;
      end
    endcase
  end

  assign sw_if.o_Switch = switch_q;
  assign sw_if.o_Rise   = rise_q;
  assign sw_if.o_Fall   = fall_q;

endmodule

// File: tb/tb_switch_debounce_filter.sv
// Directed bench for switch_debounce_filter with DEBOUNCE_LIMIT=4, SYNC_STAGES=2:
// a clean edge driven just after edge N must be accepted at edge N+6.
module tb_switch_debounce_filter;

  logic i_Clk;
  logic i_Rst_L;

  switch_debounce_filter_if sw_if ();

  switch_debounce_filter #(
    .DEBOUNCE_LIMIT(4),
    .CNT_WIDTH     (3),
    .SYNC_STAGES   (2)
  ) u_dut (
    .i_Clk  (i_Clk),
    .i_Rst_L(i_Rst_L),
    .sw_if  (sw_if.slave)
  );

  initial i_Clk = 1'b0;
  always #20 i_Clk = ~i_Clk;

  int n_checks = 0;
  int n_errors = 0;
  int rise_cnt = 0;
  int fall_cnt = 0;
  bit overlap_seen = 1'b0;
  bit b2b_seen = 1'b0;
  bit prev_strobe = 1'b0;
  logic [7:0] char_q = "0";

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // One clock edge, then sample outputs 1 time unit later; tracks strobes and
  // models the downstream character driver stepping on each rise.
  task automatic tick();
    @(posedge i_Clk);
    #1;
    if (sw_if.o_Rise) begin
      rise_cnt++;
      char_q = char_q + 8'd1;
    end
    if (sw_if.o_Fall) fall_cnt++;
    if (sw_if.o_Rise && sw_if.o_Fall) overlap_seen = 1'b1;
    if (prev_strobe && (sw_if.o_Rise || sw_if.o_Fall)) b2b_seen = 1'b1;
    prev_strobe = sw_if.o_Rise | sw_if.o_Fall;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  int r0;
  int f0;
  int rise_at;
  bit bad;

  initial begin
    i_Rst_L = 1'b0;
    sw_if.i_Switch = 1'b0;
    ticks(3);
    check_val("reset_o_Switch", {31'd0, sw_if.o_Switch}, 32'd0);
    check_val("reset_o_Rise", {31'd0, sw_if.o_Rise}, 32'd0);
    check_val("reset_o_Fall", {31'd0, sw_if.o_Fall}, 32'd0);

    // Idle after reset release
    i_Rst_L = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (sw_if.o_Switch || sw_if.o_Rise || sw_if.o_Fall) bad = 1'b1;
    end
    check_val("idle_outputs_quiet", {31'd0, bad}, 32'd0);
    check_val("idle_no_rise", rise_cnt, 0);

    // Clean press
    sw_if.i_Switch = 1'b1;
    bad = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      if (sw_if.o_Switch || sw_if.o_Rise) bad = 1'b1;
    end
    check_val("press_early_quiet", {31'd0, bad}, 32'd0);
    tick();
    check_val("press_o_Switch_n6", {31'd0, sw_if.o_Switch}, 32'd1);
    check_val("press_o_Rise_n6", {31'd0, sw_if.o_Rise}, 32'd1);
    tick();
    check_val("press_o_Rise_n7", {31'd0, sw_if.o_Rise}, 32'd0);
    check_val("press_o_Switch_n7", {31'd0, sw_if.o_Switch}, 32'd1);
    ticks(10);
    check_val("press_single_rise", rise_cnt, 1);

    // Clean release
    sw_if.i_Switch = 1'b0;
    bad = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      if (!sw_if.o_Switch || sw_if.o_Fall) bad = 1'b1;
    end
    check_val("release_early_hold", {31'd0, bad}, 32'd0);
    tick();
    check_val("release_o_Switch_n6", {31'd0, sw_if.o_Switch}, 32'd0);
    check_val("release_o_Fall_n6", {31'd0, sw_if.o_Fall}, 32'd1);
    check_val("release_o_Rise_n6", {31'd0, sw_if.o_Rise}, 32'd0);
    tick();
    check_val("release_o_Fall_n7", {31'd0, sw_if.o_Fall}, 32'd0);
    ticks(5);

    // Bounce: 3 high, 1 low, 3 high, low; never qualifies
    r0 = rise_cnt;
    sw_if.i_Switch = 1'b1; ticks(3);
    sw_if.i_Switch = 1'b0; ticks(1);
    sw_if.i_Switch = 1'b1; ticks(3);
    sw_if.i_Switch = 1'b0; ticks(6);
    check_val("bounce_o_Switch", {31'd0, sw_if.o_Switch}, 32'd0);
    check_val("bounce_no_rise", rise_cnt - r0, 0);
    sw_if.i_Switch = 1'b1;
    rise_at = 0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (sw_if.o_Rise) rise_at = k;
    end
    check_val("bounce_settle_rise_at", rise_at, 6);
    check_val("bounce_settle_one_rise", rise_cnt - r0, 1);
    sw_if.i_Switch = 1'b0;
    ticks(10);
    check_val("bounce_released", {31'd0, sw_if.o_Switch}, 32'd0);

    // Reset mid-WAIT_HIGH with the pin held high
    r0 = rise_cnt;
    f0 = fall_cnt;
    sw_if.i_Switch = 1'b1;
    ticks(2);
    i_Rst_L = 1'b0;
    ticks(2);
    check_val("midwait_rst_o_Switch", {31'd0, sw_if.o_Switch}, 32'd0);
    check_val("midwait_rst_no_rise", rise_cnt - r0, 0);
    i_Rst_L = 1'b1;
    rise_at = 0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (sw_if.o_Rise) rise_at = k;
    end
    check_val("midwait_rise_after_release", rise_at, 6);
    check_val("midwait_one_rise", rise_cnt - r0, 1);

    // Reset while o_Switch=1: asynchronous drop, no fall strobe
    i_Rst_L = 1'b0;
    sw_if.i_Switch = 1'b0;
    #1;
    check_val("async_rst_o_Switch", {31'd0, sw_if.o_Switch}, 32'd0);
    ticks(2);
    i_Rst_L = 1'b1;
    ticks(10);
    check_val("async_rst_no_fall", fall_cnt - f0, 0);

    // Chain: three bouncy presses step the character driver 1, 2, 3
    r0 = rise_cnt;
    char_q = "0";
    for (int p = 1; p <= 3; p++) begin
      for (int e = 0; e < 10; e++) begin
        sw_if.i_Switch = (e % 2 == 0);
        tick();
      end
      sw_if.i_Switch = 1'b1;
      ticks(10);
      check_val($sformatf("chain_char_%0d", p), {24'd0, char_q}, {24'd0, 8'h30 + 8'(p)});
      for (int e = 0; e < 10; e++) begin
        sw_if.i_Switch = (e % 2 != 0);
        tick();
      end
      sw_if.i_Switch = 1'b0;
      ticks(10);
    end
    check_val("chain_three_rises", rise_cnt - r0, 3);

    check_val("strobes_never_overlap", {31'd0, overlap_seen}, 32'd0);
    check_val("strobes_never_b2b", {31'd0, b2b_seen}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
